// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state enum, mode constants and one-hot helper for the sequenced decoder.
package decoder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam int MAX_W = 256;
  function automatic logic [MAX_W-1:0] onehot(input logic [7:0] sel);
    return MAX_W'(1) << sel;
  endfunction
endpackage

// File: rtl/decoder_prescaler.sv
// decoder_prescaler: dwell counter that pulses advance once every div+1 enabled cycles.
module decoder_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             advance
);
  logic [DIV_W-1:0] cnt;
  // >= rather than == so a div lowered below cnt advances at once instead of overflowing
  assign advance = enable & ~clear & (cnt >= div);
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= advance ? '0 : cnt + DIV_W'(1);
  end
endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered N-to-2^N one-hot decoder with DIRECT (handshaked) and SCAN (rotating) modes.
// Define DECODER_ACTIVE_LOW_EN for a 74138-style inverted output.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             wrap
);
  state_t state, state_nx;
  logic [SEL_W-1:0] idx, idx_nx;
  logic [OUT_W-1:0] oh, oh_nx;
  logic valid_nx, wrap_nx, scan_run, adv, hs;
  assign in_ready = en & (mode == MODE_DIRECT) & ~rst;
  assign hs = in_valid & in_ready;
  assign scan_run = en & (mode == MODE_SCAN) & (state == ST_SCAN);
  decoder_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk(clk), .rst(rst), .clear(~scan_run), .enable(scan_run), .div(div), .advance(adv)
  );
  always_comb begin
    state_nx = !en ? ST_IDLE : (mode == MODE_SCAN ? ST_SCAN : ST_DIRECT);
    idx_nx = '0;
    oh_nx = '0;
    valid_nx = 1'b0;
    wrap_nx = 1'b0;
    if (state_nx == ST_DIRECT) begin
      oh_nx = hs ? OUT_W'(onehot(8'(sel))) : (state == ST_DIRECT ? oh : '0);
      valid_nx = hs | ((state == ST_DIRECT) & out_valid);
    end else if (state_nx == ST_SCAN) begin
      idx_nx = !scan_run ? '0 : (adv ? idx + SEL_W'(1) : idx);
      oh_nx = OUT_W'(onehot(8'(idx_nx)));
      valid_nx = 1'b1;
      wrap_nx = scan_run & adv & (idx == SEL_W'(OUT_W-1));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx <= '0;
      oh <= '0;
      out_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      oh <= oh_nx;
      out_valid <= valid_nx;
      wrap <= wrap_nx;
    end
  end
`ifdef DECODER_ACTIVE_LOW_EN
  assign out = ~oh;
`else
  assign out = oh;
`endif
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: random and directed stimulus checked every cycle against a behavioural model.
module tb_onehot_decoder_seq;
  localparam int SEL_W = 3, OUT_W = 8, DIV_W = 8;
  logic clk = 0, rst = 1, en = 1, mode = 0, in_valid = 1, in_ready, out_valid, wrap;
  logic [SEL_W-1:0] sel = 3;
  logic [DIV_W-1:0] div = 0;
  logic [OUT_W-1:0] out;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  int m_st = 0, m_line = 0, m_dwell = 0;
  logic [7:0] m_out = 0;
  logic m_valid = 0, m_wrap = 0;

  onehot_decoder_seq #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .div(div), .out(out), .out_valid(out_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] phys(input logic [7:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Line shown after an edge in SCAN: restart at 0 on entry, else move on once the dwell reaches div.
  function automatic int next_line(input int st, input int line, input int dwell, input int d);
    if (st != 2) return 0;
    return (dwell >= d) ? (line + 1) % 8 : line;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst || !en) begin
      m_st <= 0; m_line <= 0; m_dwell <= 0;
      m_out <= 0; m_valid <= 0; m_wrap <= 0;
    end else if (!mode) begin
      m_st <= 1; m_line <= 0; m_dwell <= 0; m_wrap <= 0;
      if (in_valid) begin
        m_out <= 8'(1 << sel); m_valid <= 1;
      end else if (m_st != 1) begin
        m_out <= 0; m_valid <= 0;
      end
    end else begin
      m_st <= 2;
      m_line <= next_line(m_st, m_line, m_dwell, int'(div));
      m_dwell <= (m_st != 2 || m_dwell >= int'(div)) ? 0 : m_dwell + 1;
      m_out <= 8'(1 << next_line(m_st, m_line, m_dwell, int'(div)));
      m_valid <= 1;
      m_wrap <= (m_st == 2) && (m_dwell >= int'(div)) && (m_line == 7);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("out", out, phys(m_out));
      check("out_valid", out_valid, m_valid);
      check("wrap", wrap, m_wrap);
      check("in_ready", in_ready, en & ~mode & ~rst);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick();
    chk_on = 1;
    tick();
    check("rst_out", out, phys(8'h00));
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    rst = 0;
    tick();
    check("first_accept", out, phys(8'h08));
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      check("direct_seq", out, phys(8'(1 << i)));
    end
    in_valid = 0;
    sel = 1;
    tick(3);
    check("direct_hold", out, phys(8'h80));
    check("direct_hold_v", out_valid, 1);
    mode = 1; div = 2;
    tick();
    check("scan_entry", out, phys(8'h01));
    check("scan_entry_wrap", wrap, 0);
    tick(23);
    check("scan_pre_wrap", out, phys(8'h80));
    check("scan_no_wrap_yet", wrap, 0);
    tick();
    check("scan_wrap_out", out, phys(8'h01));
    check("scan_wrap", wrap, 1);
    div = 0;
    tick(10);
    check("div0_line", out, phys(8'h04));
    div = 5;
    tick(4);
    check("div5_dwell", out, phys(8'h04));
    div = 1;
    tick();
    check("div_lowered", out, phys(8'h08));
    div = 0;
    tick();
    check("mid_scan", out, phys(8'h10));
    en = 0;
    tick();
    check("en_off_out", out, phys(8'h00));
    check("en_off_valid", out_valid, 0);
    en = 1;
    tick();
    check("reentry_out", out, phys(8'h01));
    check("reentry_wrap", wrap, 0);
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      sel = 3'($urandom);
      in_valid = 1'($urandom);
      if ($urandom_range(0, 15) == 0) div = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Registered, parametrised N-to-2^N one-hot decoder with two modes.
- DIRECT: a handshaked binary select is decoded into a one-hot output register.
- SCAN: an internal prescaled counter rotates the one-hot output autonomously, for row/LED/mux strobing.
- Sits between control logic and a strobe/select fabric; generalises the fixed 3-to-8 combinational decoder.

Parameters:
- SEL_W, 3, select width.
- OUT_W, 2**SEL_W, one-hot output width (derived; do not override).
- DIV_W, 8, width of the scan prescaler divisor.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  block enable; 0 forces output inactive
- mode  input  1  0 = DIRECT, 1 = SCAN
- sel  input  SEL_W  binary select (DIRECT)
- in_valid  input  1  sel valid
- in_ready  output  1  block accepts sel
- div  input  DIV_W  scan dwell = div+1 cycles per output line
- out  output  OUT_W  registered one-hot output
- out_valid  output  1  out holds a decoded/scanned value
- wrap  output  1  one-cycle pulse when scan index wraps from OUT_W-1 to 0

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything. After reset: out=0, out_valid=0, wrap=0, scan index=0, prescaler=0, state=IDLE.
- in_ready is combinational: in_ready = en & ~mode & ~rst.
- States: IDLE, DIRECT, SCAN.
- Transitions, evaluated each cycle in this priority order:
  - en=0 -> IDLE. Next cycle: out=0, out_valid=0, wrap=0, prescaler=0, index=0.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- DIRECT:
  - On in_valid & in_ready: out = 1<<sel and out_valid=1 on the next edge (latency 1).
  - Without a handshake, out and out_valid hold.
  - Entering DIRECT from SCAN or IDLE clears out and out_valid on the entry edge, unless a handshake occurs on that same edge; the decoded value then wins.
- SCAN:
  - On the entry edge: index=0, prescaler=0, out=1, out_valid=1.
  - Each cycle: if prescaler >= div, then prescaler=0 and index advances (OUT_W-1 -> 0); otherwise prescaler increments.
  - out = 1<<index, registered; each line is active for exactly div+1 cycles.
  - wrap=1 for exactly the cycle in which out returns to bit 0 after bit OUT_W-1. It is never asserted on the entry cycle.
  - div=0: advance every cycle.
  - div lowered below the current prescaler: the >= compare forces an advance on the next edge. There is no stall and no overflow.
  - in_valid is ignored; in_ready=0.
- Arithmetic: the prescaler is DIV_W bits unsigned; the index is SEL_W bits and wraps naturally because OUT_W = 2**SEL_W.
- Invariant: out is always zero or exactly one-hot. No glitching, since all outputs are registered.

Optional Feature:
- Macro DECODER_ACTIVE_LOW_EN.
- Defined: out is the bitwise inverse of the one-hot value, as a 74138-style active-low output. Reset, IDLE and cleared states drive all ones. out_valid and wrap are unchanged.
- Undefined: active-high as described above.

Decomposition:
- Package decoder_pkg holds:
  - the state enum (ST_IDLE, ST_DIRECT, ST_SCAN);
  - mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - a function onehot(sel) returning 1<<sel.
- One natural sub-module, decoder_prescaler: the DIV_W counter, with inputs clear, div and enable, and a one-cycle advance pulse as output.

Test Plan:
- rst=1 for 2 cycles with en=1, in_valid=1 -> out=8'h00, out_valid=0, in_ready=0 throughout; after release, the first accepted sel appears one cycle later.
- DIRECT, en=1, sel 0..7 back-to-back with in_valid=1 -> out = 01,02,04,...,80, each one cycle after its accept; a gap in in_valid holds the last value.
- SCAN, div=2 -> out steps 01,02,...,80, each for 3 cycles; wrap pulses once, in the cycle out returns to 01 (cycle 24 after entry).
- SCAN, div=0, then div changed 5->1 while prescaler=4 -> advance every cycle; the div change forces an advance on the next edge.
- en dropped mid-SCAN with out=8'h10 -> next cycle out=0, out_valid=0. en re-raised in SCAN -> restarts at 01, with no wrap on entry.
- Build with DECODER_ACTIVE_LOW_EN, sel=3 -> out=8'hF7; after reset out=8'hFF.
